// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Multi-cycle command front-end for the 8-bit arithmetic cells. One command
// is taken at a time over the cmd_* port. It is executed in EXEC or, for
// DIV/MOD in the sequential build, in the iterative DIV state. The result is
// then held on the rsp_* port until the consumer takes it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds valid and its payload stable until that
// edge. ready may depend on state but never on the same-cycle valid.
//
// Ports
//   clk         system clock, all state on the rising edge
//   rst         synchronous, active-high reset
//   cmd_valid   command present
//   cmd_ready   block can accept a command (IDLE and not in reset)
//   cmd_op      0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 EQ, 6/7 illegal
//   cmd_a/b     unsigned operands, DATA_W bits
//   rsp_valid   result present (RESP state)
//   rsp_ready   consumer accepts result
//   rsp_result  2*DATA_W result, stable while rsp_valid is high
//   rsp_flags   [0] zero, [1] div_by_zero, [2] illegal_op
//
// Build option
//   JSILICON_SEQ_DIV_EN  defined: DIV/MOD with b!=0 use a restoring divider,
//                        one quotient bit per cycle (latency DATA_W+1).
//                        undefined: DIV/MOD use a combinational divide in
//                        EXEC, so every op has latency 2.
//
// The FSM state is held in the named register 'state' (type state_t) so
// checkers can bind to it directly.
// ---------------------------------------------------------------------------
module alu_sequencer #(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [DATA_W-1:0]     cmd_a,
   input  logic [DATA_W-1:0]     cmd_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [2*DATA_W-1:0]   rsp_result,
   output logic [2:0]            rsp_flags
);

   localparam int RES_W = 2 * DATA_W;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_MOD = 3'd4;
   localparam logic [2:0] OP_EQ  = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DIV  = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t              state;
   logic [2:0]          op_q;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   b_q;

   logic                cmd_fire;

   // The single subtractor: SUB uses it in EXEC, the divider reuses it for
   // its trial subtraction in DIV. Its top bit is the borrow.
   logic [DATA_W:0]     sub_lhs;
   logic [DATA_W:0]     sub_diff;

   logic [RES_W-1:0]    exec_result;
   logic                exec_dbz;
   logic                exec_ill;

`ifdef JSILICON_SEQ_DIV_EN
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   logic [DATA_W-1:0]   rem_q;      // partial remainder, always < b
   logic [DATA_W-1:0]   quo_q;      // dividend shifting out, quotient in
   logic [CNT_W-1:0]    cnt_q;
   logic [DATA_W:0]     rem_shift;
   logic [DATA_W-1:0]   rem_next;
   logic [DATA_W-1:0]   quo_next;
   logic [RES_W-1:0]    div_result;
`endif

   assign cmd_ready = (state == S_IDLE) && !rst;
   assign rsp_valid = (state == S_RESP);
   assign cmd_fire  = cmd_valid && cmd_ready;

   // ------------------------------------------------------------------
   // Shared subtractor operand select
   // ------------------------------------------------------------------
`ifdef JSILICON_SEQ_DIV_EN
   assign rem_shift = {rem_q, quo_q[DATA_W-1]};
   assign sub_lhs   = (state == S_DIV) ? rem_shift : {1'b0, a_q};
`else
   assign sub_lhs   = {1'b0, a_q};
`endif
   assign sub_diff  = sub_lhs - {1'b0, b_q};

`ifdef JSILICON_SEQ_DIV_EN
   // Restoring step: keep the difference when the trial subtraction did not
   // borrow, and shift the matching quotient bit in at the bottom.
   always_comb begin
      rem_next   = '0;
      quo_next   = '0;
      div_result = '0;
      if (sub_diff[DATA_W]) begin
         rem_next = rem_shift[DATA_W-1:0];
      end else begin
         rem_next = sub_diff[DATA_W-1:0];
      end
      quo_next = {quo_q[DATA_W-2:0], ~sub_diff[DATA_W]};
      if (op_q == OP_DIV) begin
         div_result = RES_W'(quo_next);
      end else begin
         div_result = RES_W'(rem_next);
      end
   end
`endif

   // ------------------------------------------------------------------
   // EXEC datapath, computed from the latched operands
   // ------------------------------------------------------------------
   always_comb begin
      exec_result = '0;
      exec_dbz    = 1'b0;
      exec_ill    = 1'b0;
      case (op_q)
         OP_ADD: exec_result = RES_W'(a_q) + RES_W'(b_q);
         // Zero-extending the (DATA_W+1)-bit difference puts the borrow
         // at bit DATA_W, above the modulo-2^DATA_W difference.
         OP_SUB: exec_result = RES_W'(sub_diff);
         OP_MUL: exec_result = RES_W'(a_q) * RES_W'(b_q);
         OP_DIV, OP_MOD: begin
            // Divide by zero always resolves here, in both builds. In the
            // sequential build a non-zero divisor never reaches EXEC.
            if (b_q == '0) begin
               exec_dbz = 1'b1;
            end
`ifndef JSILICON_SEQ_DIV_EN
            else if (op_q == OP_DIV) begin
               exec_result = RES_W'(a_q / b_q);
            end else begin
               exec_result = RES_W'(a_q % b_q);
            end
`endif
         end
         OP_EQ:  exec_result = {{(RES_W-1){1'b0}}, (a_q == b_q)};
         default: exec_ill = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------
   // Control FSM and registered response
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         rsp_result <= '0;
         rsp_flags  <= '0;
`ifdef JSILICON_SEQ_DIV_EN
         rem_q      <= '0;
         quo_q      <= '0;
         cnt_q      <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_fire) begin
                  op_q  <= cmd_op;
                  a_q   <= cmd_a;
                  b_q   <= cmd_b;
                  state <= S_EXEC;
`ifdef JSILICON_SEQ_DIV_EN
                  if ((cmd_op == OP_DIV || cmd_op == OP_MOD) && cmd_b != '0) begin
                     state <= S_DIV;
                     rem_q <= '0;
                     quo_q <= cmd_a;
                     cnt_q <= '0;
                  end
`endif
               end
            end
            S_EXEC: begin
               rsp_result <= exec_result;
               rsp_flags  <= {exec_ill, exec_dbz, (exec_result == '0)};
               state      <= S_RESP;
            end
`ifdef JSILICON_SEQ_DIV_EN
            S_DIV: begin
               rem_q <= rem_next;
               quo_q <= quo_next;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  rsp_result <= div_result;
                  rsp_flags  <= {2'b00, (div_result == '0)};
                  state      <= S_RESP;
               end
            end
`endif
            S_RESP: begin
               if (rsp_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Bench for alu_sequencer (DATA_W = 8). The driver issues commands and pushes
// the expected {flags, result} and the expected first rsp_valid cycle into
// queues. A monitor on the falling edge compares every response cycle against
// the queue head and pops on the response handshake. A separate process drives
// rsp_ready according to rdy_mode (0 random, 1 low, 2 high).
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

   localparam int W  = 8;
   localparam int RW = 2 * W;
   localparam int EW = 3 + RW;

   logic            clk = 1'b0;
   logic            rst;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [2:0]      cmd_op;
   logic [W-1:0]    cmd_a;
   logic [W-1:0]    cmd_b;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [RW-1:0]   rsp_result;
   logic [2:0]      rsp_flags;

   logic [EW-1:0]   exp_q[$];
   int              exp_cyc_q[$];
   int              n_checks = 0;
   int              n_fails  = 0;
   int              cyc      = 0;
   int              rdy_mode = 1;
   bit              prev_valid = 1'b0;

   alu_sequencer #(.DATA_W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags)
   );

   // ---------------- clock / cycle counter / watchdog ----------------
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: actual timeout, required finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- rsp_ready driver ----------------
   always begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       rsp_ready = 1'($urandom_range(0, 1));
         1:       rsp_ready = 1'b0;
         default: rsp_ready = 1'b1;
      endcase
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference model straight from the result rules.
   function automatic logic [EW-1:0] model(input int op, input int a, input int b);
      int r;
      bit dbz;
      bit ill;
      r = 0; dbz = 0; ill = 0;
      case (op)
         0: r = a + b;
         1: begin r = a - b; if (r < 0) r = r + 512; end
         2: r = a * b;
         3: if (b == 0) dbz = 1; else r = a / b;
         4: if (b == 0) dbz = 1; else r = a % b;
         5: r = (a == b) ? 1 : 0;
         default: ill = 1;
      endcase
      return {ill, dbz, (r == 0), RW'(r)};
   endfunction

   function automatic int latency(input int op, input int b);
`ifdef JSILICON_SEQ_DIV_EN
      if ((op == 3 || op == 4) && b != 0) return W + 1;
`endif
      return 2;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
               if (!prev_valid) check("rsp_latency_cycle", cyc, exp_cyc_q[0]);
               check("rsp_flags_result", {rsp_flags, rsp_result}, exp_q[0]);
               check("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
               if (rsp_ready) begin
                  void'(exp_q.pop_front());
                  void'(exp_cyc_q.pop_front());
               end
            end
         end
         prev_valid = rsp_valid;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [EW-1:0] exp);
      bit ok;
      ok = 1'b0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         exp_q.push_back(exp);
         exp_cyc_q.push_back(cyc + latency(int'(op), int'(b)));
      end else begin
         check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   // Returns on a falling edge with all expected responses consumed.
   task automatic drain();
      @(negedge clk);
      rdy_mode = 2;
      for (int t = 0; t < 60; t++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      check("drain_queue_empty", exp_q.size(), 32'd0);
   endtask

   // ---------------- directed table ----------------
   typedef struct packed {
      logic [2:0]    op;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [EW-1:0] exp;
   } vec_t;

   vec_t dir_vecs[16];

   initial begin
      dir_vecs[0]  = '{3'd0, 8'd200, 8'd100, {3'b000, 16'h012C}};
      dir_vecs[1]  = '{3'd1, 8'd5,   8'd10,  {3'b000, 16'h01FB}};
      dir_vecs[2]  = '{3'd2, 8'd255, 8'd255, {3'b000, 16'hFE01}};
      dir_vecs[3]  = '{3'd3, 8'd200, 8'd7,   {3'b000, 16'h001C}};
      dir_vecs[4]  = '{3'd4, 8'd200, 8'd7,   {3'b000, 16'h0004}};
      dir_vecs[5]  = '{3'd3, 8'd9,   8'd0,   {3'b011, 16'h0000}};
      dir_vecs[6]  = '{3'd7, 8'd9,   8'd3,   {3'b101, 16'h0000}};
      dir_vecs[7]  = '{3'd5, 8'd5,   8'd5,   {3'b000, 16'h0001}};
      dir_vecs[8]  = '{3'd5, 8'd5,   8'd6,   {3'b001, 16'h0000}};
      dir_vecs[9]  = '{3'd0, 8'd0,   8'd0,   {3'b001, 16'h0000}};
      dir_vecs[10] = '{3'd1, 8'd7,   8'd7,   {3'b001, 16'h0000}};
      dir_vecs[11] = '{3'd4, 8'd9,   8'd0,   {3'b011, 16'h0000}};
      dir_vecs[12] = '{3'd6, 8'd1,   8'd1,   {3'b101, 16'h0000}};
      dir_vecs[13] = '{3'd3, 8'd255, 8'd1,   {3'b000, 16'h00FF}};
      dir_vecs[14] = '{3'd4, 8'd6,   8'd3,   {3'b001, 16'h0000}};
      dir_vecs[15] = '{3'd1, 8'd0,   8'd255, {3'b000, 16'h0101}};
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [2:0] r_op;
      logic [W-1:0] r_a;
      logic [W-1:0] r_b;
      bit seen;
      int k;

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
      rdy_mode = 1;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_result", 32'(rsp_result), 32'd0);
      check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

      // directed vectors with random back-pressure
      rdy_mode = 0;
      for (int i = 0; i < 16; i++) send(dir_vecs[i].op, dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].exp);
      drain();

      // hold the response for 5 cycles, pulse an ignored command meanwhile
      rdy_mode = 1;
      send(3'd0, 8'd3, 8'd4, {3'b000, 16'h0007});
      seen = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (rsp_valid) begin seen = 1'b1; break; end
      end
      check("hold_rsp_seen", 32'(seen), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 8'd9; cmd_b = 8'd9;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rdy_mode = 2;
      @(negedge clk);
      check("hold_rsp_valid_still", 32'(rsp_valid), 32'd1);
      @(negedge clk);
      check("ready_after_rsp", 32'(cmd_ready), 32'd1);
      check("valid_drop_after_rsp", 32'(rsp_valid), 32'd0);

      // reset during a DIV command
      rdy_mode = 1;
      send(3'd3, 8'd200, 8'd7, {3'b000, 16'h001C});
      k = cyc - 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      exp_cyc_q.delete();
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_cycle", cyc, k + 4);
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_rsp_result", 32'(rsp_result), 32'd0);
      check("midrst_rsp_flags", 32'(rsp_flags), 32'd0);
      check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check("midrst_cmd_ready_after", 32'(cmd_ready), 32'd1);
      rdy_mode = 2;
      for (int t = 0; t < 12; t++) begin
         @(negedge clk);
         check("no_stale_rsp", 32'(rsp_valid), 32'd0);
      end

      // randomized commands against the model
      rdy_mode = 0;
      for (int i = 0; i < 60; i++) begin
         r_op = 3'($urandom_range(0, 7));
         r_a  = W'($urandom_range(0, 255));
         r_b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 255));
         send(r_op, r_a, r_b, model(int'(r_op), int'(r_a), int'(r_b)));
      end
      drain();
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle command front-end for the 8-bit arithmetic cells (add, subtract, multiply, divide/modulo, equality). It accepts one operation at a time over a valid/ready command port, computes the result, and returns a registered 16-bit result with status flags over a valid/ready response port. It sits between the instruction/control logic and the arithmetic datapath, and adds flow control and an optional iterative divider.

## Interface
- DATA_W, default 8: operand width; result width is 2*DATA_W.

- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 EQ, 6/7 illegal
- cmd_a  in  DATA_W  operand A, unsigned
- cmd_b  in  DATA_W  operand B, unsigned
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  2*DATA_W  result
- rsp_flags  out  3  [0] zero (rsp_result==0), [1] div_by_zero, [2] illegal_op

## Operation
- States: IDLE, EXEC, DIV, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op/a/b. Go to DIV if op is DIV/MOD, b!=0 and JSILICON_SEQ_DIV_EN is defined; otherwise go to EXEC.
- EXEC: compute combinationally from the latched operands, register result and flags, go to RESP.
- DIV: restoring divider, one quotient bit per cycle, MSB first, DATA_W cycles. After the last iteration, register the result and go to RESP.
- RESP: rsp_valid=1. rsp_result and rsp_flags hold stable until rsp_valid&rsp_ready. On that handshake, go to IDLE.
- cmd_ready=0 in EXEC, DIV and RESP. There is no overlap between commands. cmd_valid in those states is ignored, not queued.
- Result rules (upper bits are zero unless stated):
  - ADD: [8:0]=a+b, bit 8 is the carry.
  - SUB: [7:0]=(a-b) mod 256, bit 8 = borrow (a<b).
  - MUL: full 16-bit product.
  - DIV: quotient. MOD: remainder.
  - EQ: bit 0 = (a==b).
- Divide by zero (DIV or MOD with b==0): always takes the EXEC path. Result 0, flags div_by_zero=1 and zero=1.
- Illegal opcode: result 0, flags illegal_op=1 and zero=1.
- The zero flag is computed from the final rsp_result.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_result 0, rsp_flags 0, divider registers 0. cmd_ready is 0 while rst is high and 1 in the first cycle after rst falls.
- Command accepted in cycle k (cmd_valid&cmd_ready high at the edge ending cycle k):
  - Non-divider ops: EXEC in cycle k+1, rsp_valid high from cycle k+2.
  - Sequential DIV/MOD: DIV state in cycles k+1..k+DATA_W, rsp_valid high from cycle k+DATA_W+1 (k+9 for DATA_W=8).
- Response accepted in cycle r: state IDLE and cmd_ready=1 in cycle r+1. rsp_valid drops in cycle r+1. Minimum issue interval is 3 cycles.
- rsp_ready high before rsp_valid has no effect. rsp_ready held high gives single-cycle RESP.
- rst asserted in any state takes priority over all handshakes. The in-flight operation is abandoned and no response is produced.

## Configuration
- JSILICON_SEQ_DIV_EN defined: DIV/MOD with b!=0 use the DIV state and a shared-subtractor iterative divider, with latency DATA_W+1 cycles to rsp_valid.
- JSILICON_SEQ_DIV_EN undefined: the DIV state and divider registers are not built. DIV/MOD resolve in EXEC using a combinational divide, so all ops have latency 2.
- Result values and flags are identical in both builds.

## Test plan
- ADD a=200, b=100 -> rsp_result=0x012C, rsp_flags=0, rsp_valid in cycle k+2.
- SUB a=5, b=10 -> 0x01FB, flags=0. MUL a=255, b=255 -> 0xFE01, flags=0.
- DIV a=200, b=7 -> 0x001C; MOD a=200, b=7 -> 0x0004. rsp_valid in k+9 with macro, k+2 without.
- DIV a=9, b=0 -> result 0, flags=3'b011, rsp_valid in k+2 in both builds. Opcode 7 -> result 0, flags=3'b101.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> result/flags stable, cmd_ready=0, a pulsed cmd_valid is ignored. Raise rsp_ready -> cmd_ready=1 next cycle.
- Assert rst in cycle k+3 of a sequential DIV -> rsp_valid=0 and outputs 0 the next cycle, cmd_ready=1 after rst falls, no stale response ever appears.
